// File: rtl/store_narrow.sv
// store_narrow: splits byte/half/word stores into 16-bit little-endian beats.
// Misaligned or reserved-size requests are dropped with a one-cycle err pulse.
module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_size,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    state_t            state, state_d;
    logic              mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [15:0]       mem_wdata_d;
    logic [1:0]        mem_be_d;
    logic              err_d;
    logic [15:0]       hi_q, hi_d;
    logic              word_q, word_d;

    logic accept;
    logic bad;

    assign in_ready = rst_n && (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            (in_size == 2'b00): bad = 1'b0;
            (in_size == 2'b01): bad = in_addr[0];
            (in_size == 2'b10): bad = |in_addr[1:0];
            default:            bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state;
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        err_d       = 1'b0;
        hi_d        = hi_q;
        word_d      = word_q;
        unique case (state)
            IDLE: begin
                if (accept && bad) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    state_d     = BEAT0;
                    mem_valid_d = 1'b1;
                    word_d      = (in_size == 2'b10);
                    hi_d        = in_data[31:16];
                    mem_addr_d  = in_addr;
                    mem_wdata_d = in_data[15:0];
                    mem_be_d    = 2'b11;
                    if (in_size == 2'b00) begin
                        // byte lands on whichever lane addr[0] selects
                        mem_addr_d  = {in_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_d = {2{in_data[7:0]}};
                        mem_be_d    = in_addr[0] ? 2'b10 : 2'b01;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready && word_q) begin
                    state_d     = BEAT1;
                    mem_addr_d  = mem_addr + ADDR_W'(2);
                    mem_wdata_d = hi_q;
                    mem_be_d    = 2'b11;
                end else if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            err       <= 1'b0;
            hi_q      <= '0;
            word_q    <= 1'b0;
        end else begin
            state     <= state_d;
            mem_valid <= mem_valid_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            err       <= err_d;
            hi_q      <= hi_d;
            word_q    <= word_d;
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed and random stores against a beat-list model.
// Expected beats are queued by the model and popped by a handshake monitor.
module tb_store_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic [31:0] in_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        err;

    int checks;
    int failures;
    int mode;
    logic [63:0] q[$];
    logic        prev_stall;
    logic [63:0] prev_beat;

    store_narrow #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_size   (in_size),
        .in_addr   (in_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [31:0] a,
                                       input logic [15:0] d,
                                       input logic [1:0] b);
        return {14'b0, a, d, b};
    endfunction

    function automatic logic [63:0] cur();
        return pk(mem_addr, mem_wdata, mem_be);
    endfunction

    // mode 0: always ready, 1: random, 2: never ready
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && prev_stall)
            check("hold", cur(), prev_beat);
        if (rst_n && mem_valid && mem_ready) begin
            if (q.size() == 0)
                check("beat_extra", 64'(q.size()), 64'd1);
            else
                check("beat", cur(), q.pop_front());
        end
        prev_stall = rst_n && mem_valid && !mem_ready;
        prev_beat  = cur();
    end

    // Reference: returns 1 for a rejected request, else queues its beats.
    function automatic bit model(input logic [31:0] d, input logic [1:0] s,
                                 input logic [31:0] a);
        if (s == 2'd3 || (a % (32'd1 << s)) != 0)
            return 1'b1;
        case (s)
            2'd0: q.push_back(pk(a - (a % 2), 16'((d % 256) * 257),
                                 (a % 2 == 1) ? 2'd2 : 2'd1));
            2'd1: q.push_back(pk(a, 16'(d % 65536), 2'd3));
            default: begin
                q.push_back(pk(a, 16'(d % 65536), 2'd3));
                q.push_back(pk(a + 2, 16'(d / 65536), 2'd3));
            end
        endcase
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] s,
                        input logic [31:0] a, output bit bad);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_size  = s;
        in_addr  = a;
        @(negedge clk);
        check("ready_pre", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_size  = 2'($urandom_range(0, 3));
        in_addr  = $urandom;
        bad = model(d, s, a);
        tick();
        if (bad) begin
            check("err_pulse", 64'(err), 64'd1);
            check("err_nobeat", 64'(mem_valid), 64'd0);
            check("err_ready", 64'(in_ready), 64'd1);
            tick();
            check("err_clr", 64'(err), 64'd0);
        end else begin
            check("ok_noerr", 64'(err), 64'd0);
            check("ok_valid", 64'(mem_valid), 64'd1);
        end
    endtask

    task automatic wait_idle(input int exp_lat);
        int cyc;
        cyc = 1;
        while (!(in_ready && q.size() == 0) && cyc < 300) begin
            tick();
            cyc++;
        end
        if (!(in_ready && q.size() == 0)) begin
            check("idle_timeout", {62'd0, in_ready, q.size() == 0}, 64'd3);
            q.delete();
        end else if (exp_lat > 0) begin
            check("latency", 64'(cyc), 64'(exp_lat));
        end
    endtask

    initial begin
        bit bad;
        checks     = 0;
        failures   = 0;
        mode       = 0;
        prev_stall = 1'b0;
        prev_beat  = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_size    = '0;
        in_addr    = '0;
        mem_ready  = 1'b0;

        tick();
        tick();
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_beat", cur(), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rel_ready", 64'(in_ready), 64'd1);

        send(32'hDEADBEEF, 2'd2, 32'h100, bad);
        check("w_beat0", cur(), pk(32'h100, 16'hBEEF, 2'b11));
        tick();
        check("w_beat1", cur(), pk(32'h102, 16'hDEAD, 2'b11));
        check("w_ready1", 64'(in_ready), 64'd0);
        tick();
        check("w_idle", 64'(in_ready), 64'd1);
        check("w_done", 64'(mem_valid), 64'd0);

        send(32'h000000A5, 2'd0, 32'h203, bad);
        check("b_beat", cur(), pk(32'h202, 16'hA5A5, 2'b10));
        wait_idle(2);

        send(32'h00001234, 2'd1, 32'h301, bad);
        check("h_mis_bad", 64'(bad), 64'd1);

        send(32'h0, 2'd3, 32'h0, bad);
        send(32'h00001234, 2'd1, 32'h10, bad);
        check("h_beat", cur(), pk(32'h10, 16'h1234, 2'b11));
        wait_idle(2);

        mode = 2;
        send(32'hCAFEF00D, 2'd2, 32'h440, bad);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_beat0", cur(), pk(32'h440, 16'hF00D, 2'b11));
            check("stall_valid", 64'(mem_valid), 64'd1);
        end
        check("stall_pending", 64'(q.size()), 64'd2);
        mode = 0;
        wait_idle(0);

        mode = 2;
        send(32'h89ABCDEF, 2'd2, 32'h880, bad);
        mode = 0;
        tick();
        mode = 2;
        tick();
        check("r_beat1", cur(), pk(32'h882, 16'h89AB, 2'b11));
        rst_n = 1'b0;
        tick();
        check("r_valid", 64'(mem_valid), 64'd0);
        check("r_ready", 64'(in_ready), 64'd0);
        check("r_pending", 64'(q.size()), 64'd1);
        q.delete();
        rst_n = 1'b1;
        tick();
        check("r_idle", 64'(in_ready), 64'd1);
        mode = 0;

        for (int n = 0; n < 150; n++) begin
            logic [31:0] d;
            logic [31:0] a;
            logic [1:0]  s;
            d = $urandom;
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                a[1:0] = 2'($urandom_range(0, 1)) & ((s == 2'd0) ? 2'd3 : 2'd0);
            if ($urandom_range(0, 15) == 0)
                a = 32'hFFFF_FFFC;
            mode = int'($urandom_range(0, 1));
            send(d, s, a, bad);
            if (!bad)
                wait_idle((mode == 0) ? ((s == 2'd2) ? 3 : 2) : 0);
        end

        mode = 0;
        tick();
        check("end_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_narrow.md
STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of in_addr and mem_addr.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 in_valid  input  1  SHALL mark a store request on in_*.
REQ-005 in_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-006 in_data  input  32  SHALL carry the store data, right-justified (byte in [7:0], half in [15:0]).
REQ-007 in_size  input  2  SHALL encode the store size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 in_addr  input  ADDR_W  SHALL carry the byte address.
REQ-009 mem_valid  output  1  SHALL mark a valid beat on mem_*.
REQ-010 mem_ready  input  1  SHALL be the memory acceptance of the current beat.
REQ-011 mem_addr  output  ADDR_W  SHALL carry the halfword-aligned beat address, bit 0 always 0.
REQ-012 mem_wdata  output  16  SHALL carry the beat write data.
REQ-013 mem_be  output  2  SHALL carry byte enables: bit0 for lane [7:0], bit1 for lane [15:8].
REQ-014 err  output  1  SHALL pulse high for one cycle on a rejected request.

Function
REQ-015 The block SHALL narrow each 32-bit store into 16-bit little-endian memory beats.
REQ-016 The FSM SHALL have states IDLE, BEAT0, BEAT1.
REQ-017 in_ready SHALL be 1 only in IDLE with rst_n=1, and 0 in every other state.
REQ-018 A request SHALL be accepted on a cycle with in_valid=1 and in_ready=1; all request fields SHALL be registered on that edge.
REQ-019 Misaligned requests (half with addr[0]=1, word with addr[1:0]!=00) SHALL be rejected.
REQ-020 Requests with in_size=11 SHALL be rejected.
REQ-021 On a rejected request: err=1 in the next cycle only, no beat issued, state stays IDLE.
REQ-022 Byte store: one beat; mem_addr={addr[ADDR_W-1:1],0}; data[7:0] replicated on both lanes; mem_be=01 if addr[0]=0, else 10.
REQ-023 Half store: one beat; mem_addr=addr; mem_wdata=data[15:0]; mem_be=11.
REQ-024 Word store: beat 0 SHALL be mem_addr=addr, mem_wdata=data[15:0], mem_be=11.
REQ-025 Word store: beat 1 SHALL be mem_addr=addr+2 (modulo 2^ADDR_W), mem_wdata=data[31:16], mem_be=11.
REQ-026 Transition IDLE->BEAT0 on a valid accept, asserting mem_valid=1 in the cycle after accept.
REQ-027 Beat 0 complete (mem_valid&mem_ready): word -> BEAT1 with next-beat values the following cycle; byte/half -> IDLE.
REQ-028 Beat 1 complete: -> IDLE.
REQ-029 While mem_valid=1 and mem_ready=0, all mem_* outputs SHALL hold stable, with no timeout.
REQ-030 mem_ready while mem_valid=0 SHALL be ignored.
REQ-031 Minimum cost per store: 2 cycles byte/half, 3 cycles word, including the IDLE accept cycle.
REQ-032 The block SHALL never accept a new request while a beat is pending.
REQ-033 The block SHALL perform no data sign or zero extension; data bits above the stored size are don't-care.

Reset
REQ-034 With rst_n=0 at a clock edge: state=IDLE, mem_valid=0, err=0, mem_addr=0, mem_wdata=0, mem_be=00.
REQ-035 in_ready SHALL be 0 while rst_n=0.
REQ-036 Reset asserted mid-transaction (BEAT0 or BEAT1) SHALL abort it with no further beat; the first cycle after reset release is IDLE with in_ready=1.

Verification
REQ-037 Word store: data=0xDEADBEEF, addr=0x100, mem_ready=1 -> beats (0x100, 0xBEEF, 11) then (0x102, 0xDEAD, 11); in_ready back to 1 after the second beat.
REQ-038 Byte store: data=0x000000A5, addr=0x203 -> one beat: mem_addr=0x202, mem_wdata=0xA5A5, mem_be=10.
REQ-039 Half store: addr=0x301 -> err=1 for exactly one cycle, mem_valid stays 0, in_ready stays 1.
REQ-040 Word store with mem_ready held 0 for 5 cycles -> beat 0 outputs remain stable for all 5 cycles and beat 1 follows only after the handshake.
REQ-041 rst_n=0 while in BEAT1 -> mem_valid=0 on the next edge; no beat 1 handshake occurs; IDLE after release.
REQ-042 in_size=11, addr=0x0 -> err pulse, no beat issued; a back-to-back half store of 0x1234 at 0x10 -> one beat (0x10, 0x1234, 11).
